neopixel_decoder: RTL and testbench

Receive-side decoder for the single-wire NeoPixel bit code driven by each channel output. It samples one line and measures each high pulse in sys_clk cycles. It classifies each pulse as 0 or 1 against a programmable threshold, assembles bytes MSB-first and detects the latch (reset) gap that ends a frame. It is used for channel loopback checking and for daisy-chain input capture, and sits beside the channel outputs sharing the regfile timing registers.

---
 rtl/neopixel_pkg.sv | 24 ++
 rtl/neopixel_sync_edge.sv | 37 +++
 rtl/neopixel_decoder.sv | 182 ++++++++++++++++++
 tb/tb_neopixel_decoder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/neopixel_pkg.sv
// Shared types and constants for the NeoPixel receive-side decoder.
//   state_t   : decoder FSM states
//   HCNT_W    : default high-time counter width
//   HCNT_MAX  : default high-time saturation (stuck-high limit)
//   LCNT_W    : default low-time counter width (matches the latch-gap register)
//   cnt_max() : all-ones value of a counter of the given width
package neopixel_pkg;

  typedef enum logic [1:0] {
    SYNC,   // waiting for a full latch gap before trusting the line
    IDLE,   // between frames, waiting for the first rising edge
    HIGH,   // measuring a high pulse
    LOW     // measuring the low phase after a pulse
  } state_t;

  localparam int HCNT_W   = 8;
  localparam int HCNT_MAX = (1 << HCNT_W) - 1;
  localparam int LCNT_W   = 9;

  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/neopixel_sync_edge.sv
// Two-flop synchronizer plus edge detector for the asynchronous NeoPixel line.
//   clk_i   : system clock
//   rst_n_i : synchronous active-low reset (clears synchronizer to 0)
//   line_i  : asynchronous line input
//   s_o     : synchronized line level
//   rise_o  : s went 0 -> 1 this cycle
//   fall_o  : s went 1 -> 0 this cycle
module neopixel_sync_edge (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic line_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_reg;
  logic s_reg;
  logic s_q_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      meta_reg <= 1'b0;
      s_reg    <= 1'b0;
      s_q_reg  <= 1'b0;
    end else begin
      meta_reg <= line_i;
      s_reg    <= meta_reg;
      s_q_reg  <= s_reg;
    end
  end

  assign s_o    = s_reg;
  assign rise_o = s_reg & ~s_q_reg;
  assign fall_o = ~s_reg & s_q_reg;

endmodule

// File: rtl/neopixel_decoder.sv
// Receive-side NeoPixel bit-code decoder. Measures high pulses, classifies
// them against a threshold, assembles MSB-first bytes and detects the latch gap.
//   clk_i          : system clock
//   rst_n_i        : synchronous active-low reset
//   bit_code_i     : asynchronous NeoPixel line
//   reg_thr_time_i : bit = 1 when high count > this value
//   reg_rst_time_i : low cycles forming the latch gap (>= 2)
//   byte_vld_o     : one-cycle strobe, byte_data_o valid
//   byte_data_o    : last decoded byte (held)
//   frame_done_o   : one-cycle strobe at the latch gap ending a frame
//   frame_len_o    : complete bytes in the finished frame (held, saturating)
//   err_o          : one-cycle strobe on stuck-high or partial-byte error
module neopixel_decoder #(
  parameter int HCNT_W = neopixel_pkg::HCNT_W,
  parameter int LCNT_W = neopixel_pkg::LCNT_W
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       bit_code_i,
  input  logic [7:0] reg_thr_time_i,
  input  logic [8:0] reg_rst_time_i,
  output logic       byte_vld_o,
  output logic [7:0] byte_data_o,
  output logic       frame_done_o,
  output logic [7:0] frame_len_o,
  output logic       err_o
);
  import neopixel_pkg::*;

  localparam logic [HCNT_W-1:0] HCNT_SAT = HCNT_W'(cnt_max(HCNT_W));
  localparam logic [LCNT_W-1:0] LCNT_SAT = LCNT_W'(cnt_max(LCNT_W));

  logic s, rise, fall;

  neopixel_sync_edge u_sync_edge (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .line_i  (bit_code_i),
    .s_o     (s),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  state_t            state_reg, state_next;
  logic [HCNT_W-1:0] hcnt_reg, hcnt_next;
  logic [LCNT_W-1:0] lcnt_reg, lcnt_next;
  logic [2:0]        bit_cnt_reg, bit_cnt_next;
  logic [7:0]        shreg_reg, shreg_next;
  logic [7:0]        byte_cnt_reg, byte_cnt_next;
  logic              byte_vld_reg, byte_vld_next;
  logic [7:0]        byte_data_reg, byte_data_next;
  logic              frame_done_reg, frame_done_next;
  logic [7:0]        frame_len_reg, frame_len_next;
  logic              err_reg, err_next;

  logic              gap_reached;
  logic              pulse_bit;
  logic [7:0]        shreg_shifted;
  logic [LCNT_W-1:0] lcnt_inc;

  // Compares are done zero-extended so they hold for any counter width.
  assign gap_reached   = (32'(lcnt_reg) == 32'(reg_rst_time_i));
  assign pulse_bit     = (32'(hcnt_reg) > 32'(reg_thr_time_i));
  assign shreg_shifted = {shreg_reg[6:0], pulse_bit};
  assign lcnt_inc      = (lcnt_reg == LCNT_SAT) ? lcnt_reg : lcnt_reg + LCNT_W'(1);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_reg      <= SYNC;
      hcnt_reg       <= '0;
      lcnt_reg       <= '0;
      bit_cnt_reg    <= '0;
      shreg_reg      <= '0;
      byte_cnt_reg   <= '0;
      byte_vld_reg   <= 1'b0;
      byte_data_reg  <= '0;
      frame_done_reg <= 1'b0;
      frame_len_reg  <= '0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      hcnt_reg       <= hcnt_next;
      lcnt_reg       <= lcnt_next;
      bit_cnt_reg    <= bit_cnt_next;
      shreg_reg      <= shreg_next;
      byte_cnt_reg   <= byte_cnt_next;
      byte_vld_reg   <= byte_vld_next;
      byte_data_reg  <= byte_data_next;
      frame_done_reg <= frame_done_next;
      frame_len_reg  <= frame_len_next;
      err_reg        <= err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    hcnt_next       = hcnt_reg;
    lcnt_next       = lcnt_reg;
    bit_cnt_next    = bit_cnt_reg;
    shreg_next      = shreg_reg;
    byte_cnt_next   = byte_cnt_reg;
    byte_vld_next   = 1'b0;
    byte_data_next  = byte_data_reg;
    frame_done_next = 1'b0;
    frame_len_next  = frame_len_reg;
    err_next        = 1'b0;

    unique case (state_reg)
      SYNC: begin
        // Only a full quiet gap proves we are between frames.
        if (s) begin
          lcnt_next = '0;
        end else if (gap_reached) begin
          lcnt_next  = '0;
          state_next = IDLE;
        end else begin
          lcnt_next = lcnt_inc;
        end
      end

      IDLE: begin
        if (rise) begin
          hcnt_next  = HCNT_W'(1);
          state_next = HIGH;
        end
      end

      HIGH: begin
        if (fall) begin
          shreg_next   = shreg_shifted;
          bit_cnt_next = bit_cnt_reg + 3'd1;
          lcnt_next    = LCNT_W'(1);
          state_next   = LOW;
          if (bit_cnt_reg == 3'd7) begin
            byte_vld_next  = 1'b1;
            byte_data_next = shreg_shifted;
            if (byte_cnt_reg != 8'hFF) begin
              byte_cnt_next = byte_cnt_reg + 8'd1;
            end
          end
        end else if (hcnt_reg == HCNT_SAT) begin
          // Line stuck high: abandon the frame and resynchronize.
          err_next      = 1'b1;
          bit_cnt_next  = '0;
          byte_cnt_next = '0;
          lcnt_next     = '0;
          state_next    = SYNC;
        end else begin
          hcnt_next = hcnt_reg + HCNT_W'(1);
        end
      end

      LOW: begin
        if (rise) begin
          hcnt_next  = HCNT_W'(1);
          state_next = HIGH;
        end else if (gap_reached) begin
          frame_done_next = 1'b1;
          frame_len_next  = byte_cnt_reg;
          // A dangling partial byte is dropped and flagged.
          err_next        = (bit_cnt_reg != 3'd0);
          bit_cnt_next    = '0;
          byte_cnt_next   = '0;
          lcnt_next       = '0;
          hcnt_next       = '0;
          state_next      = IDLE;
        end else begin
          lcnt_next = lcnt_inc;
        end
      end

      default: state_next = SYNC;
    endcase
  end

  assign byte_vld_o   = byte_vld_reg;
  assign byte_data_o  = byte_data_reg;
  assign frame_done_o = frame_done_reg;
  assign frame_len_o  = frame_len_reg;
  assign err_o        = err_reg;

endmodule

// File: tb/tb_neopixel_decoder.sv
// Scoreboard bench for neopixel_decoder: stimulus pushes expected strobe
// events, a negedge monitor pops and compares whenever any strobe is seen.
module tb_neopixel_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bit_code;
  logic [7:0] thr;
  logic [8:0] rst_time;
  logic       byte_vld;
  logic [7:0] byte_data;
  logic       frame_done;
  logic [7:0] frame_len;
  logic       err;

  always #5 clk = ~clk;

  neopixel_decoder dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .bit_code_i     (bit_code),
    .reg_thr_time_i (thr),
    .reg_rst_time_i (rst_time),
    .byte_vld_o     (byte_vld),
    .byte_data_o    (byte_data),
    .frame_done_o   (frame_done),
    .frame_len_o    (frame_len),
    .err_o          (err)
  );

  typedef struct {
    logic       vld;
    logic [7:0] data;
    logic       done;
    logic [7:0] len;
    logic       err;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  logic mon_ok;
  int checks = 0;
  int failures = 0;

  task automatic exp_ev(input logic vld, input logic [7:0] data, input logic done,
                        input logic [7:0] len, input logic e);
    ev_t ev;
    ev.vld = vld; ev.data = data; ev.done = done; ev.len = len; ev.err = e;
    exp_q.push_back(ev);
  endtask

  // Monitor: every cycle carrying a strobe must match the next expected event.
  always @(negedge clk) begin
    if (byte_vld || frame_done || err) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event actual vld=%0b data=%02h done=%0b len=%0d err=%0b required no event",
                 byte_vld, byte_data, frame_done, frame_len, err);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_ok = (byte_vld == mon_e.vld) && (frame_done == mon_e.done) && (err == mon_e.err)
              && (!mon_e.vld || byte_data == mon_e.data)
              && (!mon_e.done || frame_len == mon_e.len);
        if (!mon_ok) begin
          failures++;
          $display("FAIL event actual vld=%0b data=%02h done=%0b len=%0d err=%0b required vld=%0b data=%02h done=%0b len=%0d err=%0b",
                   byte_vld, byte_data, frame_done, frame_len, err,
                   mon_e.vld, mon_e.data, mon_e.done, mon_e.len, mon_e.err);
        end else begin
          $display("event ok vld=%0b data=%02h done=%0b len=%0d err=%0b",
                   byte_vld, byte_data, frame_done, frame_len, err);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("check ok %s value=%0h", name, act);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_byte_vld"},   32'(byte_vld),   32'd0);
    chk({tag, "_byte_data"},  32'(byte_data),  32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_frame_len"},  32'(frame_len),  32'd0);
    chk({tag, "_err"},        32'(err),        32'd0);
  endtask

  task automatic drive(input logic v, input int n);
    bit_code = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int h, input int l);
    drive(1'b1, h);
    drive(1'b0, l);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) pulse(b[i] ? 18 : 6, 12);
  endtask

  initial begin
    rst_n    = 1'b0;
    bit_code = 1'b0;
    thr      = 8'd10;
    rst_time = 9'd50;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    drive(1'b0, 60);

    // Pulse classification: 0,1,0,1,0,0,1,1 -> 0x53
    exp_ev(1'b1, 8'h53, 1'b0, 8'd0, 1'b0);
    exp_ev(1'b0, 8'h00, 1'b1, 8'd1, 1'b0);
    pulse(6, 12); pulse(18, 12); pulse(6, 12); pulse(18, 12);
    pulse(6, 12); pulse(6, 12); pulse(18, 12); pulse(18, 12);
    drive(1'b0, 60);

    // Multi-byte frame
    exp_ev(1'b1, 8'hA5, 1'b0, 8'd0, 1'b0);
    exp_ev(1'b1, 8'h00, 1'b0, 8'd0, 1'b0);
    exp_ev(1'b1, 8'hFF, 1'b0, 8'd0, 1'b0);
    exp_ev(1'b0, 8'h00, 1'b1, 8'd3, 1'b0);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'hFF);
    drive(1'b0, 60);

    // Threshold boundary: high == thr is 0, thr+1 is 1 -> 0x55
    exp_ev(1'b1, 8'h55, 1'b0, 8'd0, 1'b0);
    exp_ev(1'b0, 8'h00, 1'b1, 8'd1, 1'b0);
    for (int i = 0; i < 8; i++) pulse((i % 2 == 1) ? 11 : 10, 12);
    drive(1'b0, 60);

    // Threshold 0 with minimum 1-cycle phases -> every pulse is 1
    thr = 8'd0;
    exp_ev(1'b1, 8'hFF, 1'b0, 8'd0, 1'b0);
    exp_ev(1'b0, 8'h00, 1'b1, 8'd1, 1'b0);
    repeat (8) pulse(1, 1);
    drive(1'b0, 60);
    thr = 8'd10;

    // Stuck high: one error, then nothing decodes until a full gap
    exp_ev(1'b0, 8'h00, 1'b0, 8'd0, 1'b1);
    drive(1'b1, 300);
    drive(1'b0, 20);
    pulse(18, 20);
    drive(1'b0, 60);
    exp_ev(1'b1, 8'h3C, 1'b0, 8'd0, 1'b0);
    exp_ev(1'b0, 8'h00, 1'b1, 8'd1, 1'b0);
    send_byte(8'h3C);
    drive(1'b0, 60);

    // Partial byte: frame_done, len 0 and err together
    exp_ev(1'b0, 8'h00, 1'b1, 8'd0, 1'b1);
    pulse(18, 12); pulse(6, 12); pulse(18, 12); pulse(18, 12); pulse(6, 12);
    drive(1'b0, 60);

    // Startup mid-frame: reset released while the line toggles
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) rst_n = 1'b1;
      pulse(12, 12);
    end
    drive(1'b0, 60);
    exp_ev(1'b1, 8'hC3, 1'b0, 8'd0, 1'b0);
    exp_ev(1'b0, 8'h00, 1'b1, 8'd1, 1'b0);
    send_byte(8'hC3);
    drive(1'b0, 60);

    // Reset mid-byte: outputs (holding C3 / len 1) clear next cycle
    pulse(18, 12); pulse(6, 12); pulse(18, 12); pulse(6, 12);
    rst_n = 1'b0;
    @(negedge clk);
    chk_outputs_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 60);
    exp_ev(1'b1, 8'h96, 1'b0, 8'd0, 1'b0);
    exp_ev(1'b0, 8'h00, 1'b1, 8'd1, 1'b0);
    send_byte(8'h96);
    drive(1'b0, 60);

    repeat (20) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
